// File: rtl/store_pkg.sv
// Shared definitions for the store path: funct3 encodings, FSM state type and
// the size/mask lookups used by both the controller and the lane aligner.
package store_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT1 = 2'd1,
        ST_BEAT2 = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        logic [3:0] m;
        case (funct3)
            F3_SB:   m = 4'b0001;
            F3_SH:   m = 4'b0011;
            F3_SW:   m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

    function automatic logic [2:0] size_bytes(input logic [2:0] funct3);
        logic [2:0] s;
        case (funct3)
            F3_SB:   s = 3'd1;
            F3_SH:   s = 3'd2;
            F3_SW:   s = 3'd4;
            default: s = 3'd0;
        endcase
        return s;
    endfunction

    function automatic logic is_legal(input logic [2:0] funct3);
        return (funct3 == F3_SB) || (funct3 == F3_SH) || (funct3 == F3_SW);
    endfunction

endpackage

// File: rtl/store_align.sv
// Byte-lane positioning for one write beat: the first beat shifts data up by the
// byte offset, the second beat carries the bytes that spilled past lane 3.
module store_align
    import store_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [3:0]  mask_i,
    input  logic [31:0] data_i,
    input  logic        beat2_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o
);

    logic [7:0]  be_wide_s;
    logic [3:0]  be_s;
    logic [31:0] shifted_s;
    logic [31:0] lane_mask_s;

    // Select the beat's enables and shifted data, then zero the unenabled lanes.
    always_comb begin
        be_wide_s   = 8'd0;
        be_s        = 4'd0;
        shifted_s   = 32'd0;
        lane_mask_s = 32'd0;
        if (beat2_i) begin
            be_s      = mask_i >> (3'd4 - {1'b0, off_i});
            shifted_s = data_i >> (6'd32 - {1'b0, off_i, 3'b000});
        end else begin
            be_wide_s = {4'd0, mask_i} << off_i;
            be_s      = be_wide_s[3:0];
            shifted_s = data_i << {off_i, 3'b000};
        end
        for (int i = 0; i < 4; i++) begin
            lane_mask_s[8*i +: 8] = {8{be_s[i]}};
        end
        be_o    = be_s;
        wdata_o = shifted_s & lane_mask_s;
    end

endmodule

// File: rtl/store_unit.sv
// Store formatter: accepts one SB/SH/SW, issues one or two word-aligned write
// beats with byte enables, and pulses done (plus err for an illegal funct3).
module store_unit
    import store_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_data,
    input  logic [2:0]  req_funct3,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    output logic        done,
    output logic        err
);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        err_q, err_d;

    logic        accept_s;
    logic        spill_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [29:0] next_word_s;

    assign accept_s    = (state_q == ST_IDLE) && req_valid;
    assign spill_s     = ({2'b00, addr_q[1:0]} + {1'b0, size_bytes(funct3_q)}) > 4'd4;
    assign next_word_s = addr_q[31:2] + 30'd1;

    store_align u_align (
        .off_i   (addr_q[1:0]),
        .mask_i  (size_mask(funct3_q)),
        .data_i  (data_q),
        .beat2_i (state_q == ST_BEAT2),
        .be_o    (be_s),
        .wdata_o (wdata_s)
    );

    // Next-state logic for the FSM and the captured request.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        funct3_d = funct3_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    addr_d   = req_addr;
                    data_d   = req_data;
                    funct3_d = req_funct3;
                    err_d    = !is_legal(req_funct3);
                    state_d  = is_legal(req_funct3) ? ST_BEAT1 : ST_FIN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BEAT1: begin
                if (mem_ack) begin
                    state_d = spill_s ? ST_BEAT2 : ST_FIN;
                end else begin
                    state_d = ST_BEAT1;
                end
            end
            ST_BEAT2: begin
                if (mem_ack) begin
                    state_d = ST_FIN;
                end else begin
                    state_d = ST_BEAT2;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State and request registers; reset drops any store in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= 32'd0;
            data_q   <= 32'd0;
            funct3_q <= 3'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            funct3_q <= funct3_d;
            err_q    <= err_d;
        end
    end

    // Outputs depend only on registered state, so they stay stable while a beat waits.
    always_comb begin
        req_ready = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        mem_be    = 4'd0;
        done      = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE:  req_ready = 1'b1;
            ST_BEAT1: begin
                mem_we    = 1'b1;
                mem_addr  = {addr_q[31:2], 2'b00};
                mem_wdata = wdata_s;
                mem_be    = be_s;
            end
            ST_BEAT2: begin
                mem_we    = 1'b1;
                mem_addr  = {next_word_s, 2'b00};
                mem_wdata = wdata_s;
                mem_be    = be_s;
            end
            ST_FIN: begin
                done = 1'b1;
                err  = err_q;
            end
            default: req_ready = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: fixed-cycle stimulus with hand-computed
// expected beats, checked one cycle-step at a time.
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_data;
    logic [2:0]  req_funct3;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic        done;
    logic        err;

    int total = 0;
    int bad   = 0;

    store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_funct3 (req_funct3),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ack    (mem_ack),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_beat(input string tag, input logic [31:0] a, input logic [3:0] be,
                            input logic [31:0] wd);
        chk({tag, ".we"},    {31'd0, mem_we}, 32'd1);
        chk({tag, ".addr"},  mem_addr, a);
        chk({tag, ".be"},    {28'd0, mem_be}, {28'd0, be});
        chk({tag, ".wdata"}, mem_wdata, wd);
        chk({tag, ".done"},  {31'd0, done}, 32'd0);
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, ".we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, ".addr"},  mem_addr, 32'd0);
        chk({tag, ".wdata"}, mem_wdata, 32'd0);
        chk({tag, ".be"},    {28'd0, mem_be}, 32'd0);
        chk({tag, ".done"},  {31'd0, done}, 32'd0);
        chk({tag, ".err"},   {31'd0, err}, 32'd0);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        req_valid  = 1'b1;
        req_addr   = a;
        req_data   = d;
        req_funct3 = f3;
        step();
        req_valid  = 1'b0;
    endtask

    task automatic chk_fin(input string tag, input logic e);
        chk({tag, ".done"},  {31'd0, done}, 32'd1);
        chk({tag, ".err"},   {31'd0, err}, {31'd0, e});
        chk({tag, ".we"},    {31'd0, mem_we}, 32'd0);
        chk({tag, ".ready"}, {31'd0, req_ready}, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = 32'd0;
        req_data   = 32'd0;
        req_funct3 = 3'd0;
        mem_ack    = 1'b0;
        step();
        chk_idle_outs("reset");
        rst_n = 1'b1;
        step();
        chk_idle_outs("post_reset");

        // SB non-spilling, immediate ack
        mem_ack = 1'b1;
        issue(32'h0000_1003, 32'h0000_00AB, 3'b000);
        chk_beat("sb.b1", 32'h0000_1000, 4'b1000, 32'hAB00_0000);
        chk("sb.ready_b1", {31'd0, req_ready}, 32'd0);
        step();
        chk_fin("sb.fin", 1'b0);
        step();
        chk_idle_outs("sb.idle");

        // SH spilling, immediate acks
        issue(32'h0000_1003, 32'h0000_BEEF, 3'b001);
        chk_beat("sh.b1", 32'h0000_1000, 4'b1000, 32'hEF00_0000);
        step();
        chk_beat("sh.b2", 32'h0000_1004, 4'b0001, 32'h0000_00BE);
        step();
        chk_fin("sh.fin", 1'b0);
        step();
        chk_idle_outs("sh.idle");

        // SW spilling with each beat held three cycles
        mem_ack = 1'b0;
        issue(32'h0000_2002, 32'h1122_3344, 3'b010);
        chk_beat("sw.b1c1", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        step();
        chk_beat("sw.b1c2", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        step();
        mem_ack = 1'b1;
        chk_beat("sw.b1c3", 32'h0000_2000, 4'b1100, 32'h3344_0000);
        step();
        mem_ack = 1'b0;
        chk_beat("sw.b2c1", 32'h0000_2004, 4'b0011, 32'h0000_1122);
        step();
        chk_beat("sw.b2c2", 32'h0000_2004, 4'b0011, 32'h0000_1122);
        step();
        mem_ack = 1'b1;
        chk_beat("sw.b2c3", 32'h0000_2004, 4'b0011, 32'h0000_1122);
        step();
        chk_fin("sw.fin", 1'b0);
        step();
        chk("sw.done_once", {31'd0, done}, 32'd0);
        chk("sw.ready_back", {31'd0, req_ready}, 32'd1);

        // SW wrapping past the top of the address space
        issue(32'hFFFF_FFFD, 32'hA1B2_C3D4, 3'b010);
        chk_beat("wrap.b1", 32'hFFFF_FFFC, 4'b1110, 32'hB2C3_D400);
        step();
        chk_beat("wrap.b2", 32'h0000_0000, 4'b0001, 32'h0000_00A1);
        step();
        chk_fin("wrap.fin", 1'b0);
        step();

        // Illegal funct3: no write, done+err next cycle
        issue(32'h0000_0010, 32'h1234_5678, 3'b011);
        chk_fin("ill.fin", 1'b1);
        step();
        chk_idle_outs("ill.idle");

        // Reset while BEAT1 of a spilling SH is stalled
        mem_ack = 1'b0;
        issue(32'h0000_1003, 32'h0000_BEEF, 3'b001);
        chk_beat("rst.b1", 32'h0000_1000, 4'b1000, 32'hEF00_0000);
        step();
        rst_n = 1'b0;
        #1;
        chk_idle_outs("rst.async");
        step();
        rst_n   = 1'b1;
        mem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst.no_we",   {31'd0, mem_we}, 32'd0);
            chk("rst.no_done", {31'd0, done}, 32'd0);
        end
        issue(32'h0000_1000, 32'hCAFE_F00D, 3'b010);
        chk_beat("rst.sw_b1", 32'h0000_1000, 4'b1111, 32'hCAFE_F00D);
        step();
        chk_fin("rst.sw_fin", 1'b0);
        step();
        chk_idle_outs("rst.sw_idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
